// File: rtl/spec_rename_table.sv
// Speculative/architectural register alias table for the rename stage.
// The speculative table is rebuilt from the commit-updated architectural table after a flush.
module spec_rename_table #(
  parameter int LREG_NUM     = 32,
  parameter int PREG_WIDTH   = 6,
  parameter int RENAME_WIDTH = 2,
  parameter int COMMIT_WIDTH = 2,
  localparam int LW          = $clog2(LREG_NUM)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [RENAME_WIDTH-1:0]          rn_valid,
  input  logic [RENAME_WIDTH-1:0]          rn_rd_wen,
  input  logic [RENAME_WIDTH*LW-1:0]       rn_lrs1,
  input  logic [RENAME_WIDTH*LW-1:0]       rn_lrs2,
  input  logic [RENAME_WIDTH*LW-1:0]       rn_lrd,
  input  logic [RENAME_WIDTH*PREG_WIDTH-1:0] rn_new_prd,
  output logic [RENAME_WIDTH*PREG_WIDTH-1:0] rn_prs1,
  output logic [RENAME_WIDTH*PREG_WIDTH-1:0] rn_prs2,
  output logic [RENAME_WIDTH*PREG_WIDTH-1:0] rn_old_prd,
  output logic                             rn_ready,
  input  logic [COMMIT_WIDTH-1:0]          cm_valid,
  input  logic [COMMIT_WIDTH*LW-1:0]       cm_lrd,
  input  logic [COMMIT_WIDTH*PREG_WIDTH-1:0] cm_prd,
  input  logic                             flush_valid
);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t                state_q, state_d;
  logic [PREG_WIDTH-1:0] srat_q [LREG_NUM];
  logic [PREG_WIDTH-1:0] srat_d [LREG_NUM];
  logic [PREG_WIDTH-1:0] arat_q [LREG_NUM];
  logic [PREG_WIDTH-1:0] arat_d [LREG_NUM];

  logic [RENAME_WIDTH-1:0] lane_wr;
  logic [RENAME_WIDTH-1:0] fire;
  logic [LW-1:0]           t1, t2, td;
  logic [PREG_WIDTH-1:0]   m1, m2, md;

  assign rn_ready = (state_q == RUN) && !flush_valid;

  always_comb begin
    lane_wr = '0;
    fire    = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      lane_wr[k] = rn_valid[k] && rn_rd_wen[k] && (rn_lrd[k*LW +: LW] != '0);
      fire[k]    = rn_ready && lane_wr[k];
    end
  end

  // Older lanes in the same group override the table; the highest older lane wins.
  always_comb begin
    rn_prs1    = '0;
    rn_prs2    = '0;
    rn_old_prd = '0;
    t1 = '0; t2 = '0; td = '0;
    m1 = '0; m2 = '0; md = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      t1 = rn_lrs1[k*LW +: LW];
      t2 = rn_lrs2[k*LW +: LW];
      td = rn_lrd[k*LW +: LW];
      m1 = srat_q[t1];
      m2 = srat_q[t2];
      md = srat_q[td];
      for (int j = 0; j < k; j++) begin
        if (lane_wr[j]) begin
          if (rn_lrd[j*LW +: LW] == t1) m1 = rn_new_prd[j*PREG_WIDTH +: PREG_WIDTH];
          if (rn_lrd[j*LW +: LW] == t2) m2 = rn_new_prd[j*PREG_WIDTH +: PREG_WIDTH];
          if (rn_lrd[j*LW +: LW] == td) md = rn_new_prd[j*PREG_WIDTH +: PREG_WIDTH];
        end
      end
      if (t1 == '0) m1 = '0;
      if (t2 == '0) m2 = '0;
      if (td == '0) md = '0;
      rn_prs1[k*PREG_WIDTH +: PREG_WIDTH]    = m1;
      rn_prs2[k*PREG_WIDTH +: PREG_WIDTH]    = m2;
      rn_old_prd[k*PREG_WIDTH +: PREG_WIDTH] = md;
    end
  end

  always_comb begin
    arat_d = arat_q;
    for (int c = 0; c < COMMIT_WIDTH; c++) begin
      if (cm_valid[c] && (cm_lrd[c*LW +: LW] != '0))
        arat_d[cm_lrd[c*LW +: LW]] = cm_prd[c*PREG_WIDTH +: PREG_WIDTH];
    end
  end

  // Recovery copies arat_d so commits landing on the copy edge are not lost.
  always_comb begin
    srat_d  = srat_q;
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (flush_valid) begin
          state_d = RECOVER;
        end else begin
          for (int k = 0; k < RENAME_WIDTH; k++) begin
            if (fire[k])
              srat_d[rn_lrd[k*LW +: LW]] = rn_new_prd[k*PREG_WIDTH +: PREG_WIDTH];
          end
        end
      end
      RECOVER: begin
        srat_d  = arat_d;
        state_d = flush_valid ? RECOVER : RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      for (int i = 0; i < LREG_NUM; i++) begin
        srat_q[i] <= PREG_WIDTH'(i);
        arat_q[i] <= PREG_WIDTH'(i);
      end
    end else begin
      state_q <= state_d;
      srat_q  <= srat_d;
      arat_q  <= arat_d;
    end
  end

endmodule

// File: tb/tb_spec_rename_table.sv
// Directed testbench for spec_rename_table: rename, bypass, x0 handling, flush recovery and reset.
module tb_spec_rename_table;

  localparam int LW = 5;
  localparam int PW = 6;
  localparam int RW = 2;
  localparam int CW = 2;

  logic               clock = 1'b0;
  logic               reset;
  logic [RW-1:0]      rn_valid, rn_rd_wen;
  logic [RW*LW-1:0]   rn_lrs1, rn_lrs2, rn_lrd;
  logic [RW*PW-1:0]   rn_new_prd, rn_prs1, rn_prs2, rn_old_prd;
  logic               rn_ready;
  logic [CW-1:0]      cm_valid;
  logic [CW*LW-1:0]   cm_lrd;
  logic [CW*PW-1:0]   cm_prd;
  logic               flush_valid;

  int checks = 0;
  int fails  = 0;
  logic [PW-1:0] v;

  spec_rename_table #(
    .LREG_NUM(32), .PREG_WIDTH(PW), .RENAME_WIDTH(RW), .COMMIT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .rn_valid(rn_valid), .rn_rd_wen(rn_rd_wen),
    .rn_lrs1(rn_lrs1), .rn_lrs2(rn_lrs2), .rn_lrd(rn_lrd),
    .rn_new_prd(rn_new_prd),
    .rn_prs1(rn_prs1), .rn_prs2(rn_prs2), .rn_old_prd(rn_old_prd),
    .rn_ready(rn_ready),
    .cm_valid(cm_valid), .cm_lrd(cm_lrd), .cm_prd(cm_prd),
    .flush_valid(flush_valid)
  );

  always #5 clock = ~clock;

  task automatic clear_inputs();
    rn_valid = '0; rn_rd_wen = '0;
    rn_lrs1 = '0; rn_lrs2 = '0; rn_lrd = '0; rn_new_prd = '0;
    cm_valid = '0; cm_lrd = '0; cm_prd = '0;
    flush_valid = 1'b0;
  endtask

  task automatic set_lane(input int k, input logic vld, input logic wen,
                          input logic [LW-1:0] s1, input logic [LW-1:0] s2,
                          input logic [LW-1:0] d, input logic [PW-1:0] np);
    rn_valid[k] = vld;
    rn_rd_wen[k] = wen;
    rn_lrs1[k*LW +: LW] = s1;
    rn_lrs2[k*LW +: LW] = s2;
    rn_lrd[k*LW +: LW] = d;
    rn_new_prd[k*PW +: PW] = np;
  endtask

  task automatic set_commit(input int c, input logic vld,
                            input logic [LW-1:0] d, input logic [PW-1:0] p);
    cm_valid[c] = vld;
    cm_lrd[c*LW +: LW] = d;
    cm_prd[c*PW +: PW] = p;
  endtask

  // Non-writing lookup of the speculative table through lane 0's lrs1 port.
  task automatic read_map(input logic [LW-1:0] l, output logic [PW-1:0] val);
    rn_valid = '0;
    rn_rd_wen = '0;
    rn_lrs1[0 +: LW] = l;
    #1;
    val = rn_prs1[0 +: PW];
  endtask

  task automatic next_cycle();
    @(posedge clock);
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (rn_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %0b expected 1", rn_ready); end
    read_map(5'd5, v);
    checks++;
    if (v !== 6'd5) begin fails++; $display("[TB] FAIL reset_map5: got %0d expected 5", v); end
    read_map(5'd31, v);
    checks++;
    if (v !== 6'd31) begin fails++; $display("[TB] FAIL reset_map31: got %0d expected 31", v); end
    next_cycle();
  endtask

  task automatic test_basic_rename();
    set_lane(0, 1'b1, 1'b1, 5'd3, 5'd0, 5'd7, 6'd40);
    #1;
    checks++;
    if (rn_prs1[0 +: PW] !== 6'd3) begin fails++; $display("[TB] FAIL basic_prs1: got %0d expected 3", rn_prs1[0 +: PW]); end
    checks++;
    if (rn_prs2[0 +: PW] !== 6'd0) begin fails++; $display("[TB] FAIL basic_prs2: got %0d expected 0", rn_prs2[0 +: PW]); end
    checks++;
    if (rn_old_prd[0 +: PW] !== 6'd7) begin fails++; $display("[TB] FAIL basic_old: got %0d expected 7", rn_old_prd[0 +: PW]); end
    next_cycle();
    read_map(5'd7, v);
    checks++;
    if (v !== 6'd40) begin fails++; $display("[TB] FAIL basic_map7: got %0d expected 40", v); end
    next_cycle();
  endtask

  task automatic test_bypass();
    set_lane(0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd4, 6'd33);
    set_lane(1, 1'b1, 1'b1, 5'd4, 5'd7, 5'd4, 6'd34);
    #1;
    checks++;
    if (rn_old_prd[0 +: PW] !== 6'd4) begin fails++; $display("[TB] FAIL bypass_old0: got %0d expected 4", rn_old_prd[0 +: PW]); end
    checks++;
    if (rn_prs1[PW +: PW] !== 6'd33) begin fails++; $display("[TB] FAIL bypass_prs1: got %0d expected 33", rn_prs1[PW +: PW]); end
    checks++;
    if (rn_old_prd[PW +: PW] !== 6'd33) begin fails++; $display("[TB] FAIL bypass_old1: got %0d expected 33", rn_old_prd[PW +: PW]); end
    checks++;
    if (rn_prs2[PW +: PW] !== 6'd40) begin fails++; $display("[TB] FAIL bypass_prs2: got %0d expected 40", rn_prs2[PW +: PW]); end
    next_cycle();
    read_map(5'd4, v);
    checks++;
    if (v !== 6'd34) begin fails++; $display("[TB] FAIL bypass_map4: got %0d expected 34", v); end
    next_cycle();
  endtask

  task automatic test_x0();
    set_lane(0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 6'd50);
    set_lane(1, 1'b1, 1'b0, 5'd0, 5'd3, 5'd0, 6'd0);
    #1;
    checks++;
    if (rn_old_prd[0 +: PW] !== 6'd0) begin fails++; $display("[TB] FAIL x0_old: got %0d expected 0", rn_old_prd[0 +: PW]); end
    checks++;
    if (rn_prs1[PW +: PW] !== 6'd0) begin fails++; $display("[TB] FAIL x0_bypass: got %0d expected 0", rn_prs1[PW +: PW]); end
    next_cycle();
    read_map(5'd0, v);
    checks++;
    if (v !== 6'd0) begin fails++; $display("[TB] FAIL x0_read: got %0d expected 0", v); end
    next_cycle();
  endtask

  task automatic test_flush_recovery();
    set_lane(0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd9, 6'd41);
    set_commit(0, 1'b1, 5'd9, 6'd20);
    next_cycle();
    flush_valid = 1'b1;
    #1;
    checks++;
    if (rn_ready !== 1'b0) begin fails++; $display("[TB] FAIL flush_ready_n: got %0b expected 0", rn_ready); end
    next_cycle();
    set_lane(0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd12, 6'd55);
    #1;
    checks++;
    if (rn_ready !== 1'b0) begin fails++; $display("[TB] FAIL flush_ready_n1: got %0b expected 0", rn_ready); end
    next_cycle();
    #1;
    checks++;
    if (rn_ready !== 1'b1) begin fails++; $display("[TB] FAIL flush_ready_n2: got %0b expected 1", rn_ready); end
    read_map(5'd9, v);
    checks++;
    if (v !== 6'd20) begin fails++; $display("[TB] FAIL flush_map9: got %0d expected 20", v); end
    read_map(5'd12, v);
    checks++;
    if (v !== 6'd12) begin fails++; $display("[TB] FAIL flush_map12: got %0d expected 12", v); end
    read_map(5'd7, v);
    checks++;
    if (v !== 6'd7) begin fails++; $display("[TB] FAIL flush_map7: got %0d expected 7", v); end
    read_map(5'd4, v);
    checks++;
    if (v !== 6'd4) begin fails++; $display("[TB] FAIL flush_map4: got %0d expected 4", v); end
    next_cycle();
  endtask

  task automatic test_commit_in_flush();
    flush_valid = 1'b1;
    set_commit(0, 1'b1, 5'd2, 6'd60);
    next_cycle();
    set_commit(0, 1'b1, 5'd6, 6'd12);
    set_commit(1, 1'b1, 5'd6, 6'd13);
    next_cycle();
    read_map(5'd2, v);
    checks++;
    if (v !== 6'd60) begin fails++; $display("[TB] FAIL cmflush_map2: got %0d expected 60", v); end
    read_map(5'd6, v);
    checks++;
    if (v !== 6'd13) begin fails++; $display("[TB] FAIL cmflush_map6: got %0d expected 13", v); end
    read_map(5'd9, v);
    checks++;
    if (v !== 6'd20) begin fails++; $display("[TB] FAIL cmflush_map9: got %0d expected 20", v); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic exp_ready [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    set_lane(0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd10, 6'd44);
    next_cycle();
    for (int c = 0; c < 5; c++) begin
      flush_valid = (c < 3);
      #1;
      checks++;
      if (rn_ready !== exp_ready[c]) begin
        fails++;
        $display("[TB] FAIL b2b_ready cycle %0d: got %0b expected %0b", c, rn_ready, exp_ready[c]);
      end
      if (c < 4) next_cycle();
    end
    read_map(5'd10, v);
    checks++;
    if (v !== 6'd10) begin fails++; $display("[TB] FAIL b2b_map10: got %0d expected 10", v); end
    next_cycle();
  endtask

  task automatic test_reset_in_recover();
    set_lane(0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd11, 6'd45);
    set_commit(0, 1'b1, 5'd11, 6'd46);
    next_cycle();
    flush_valid = 1'b1;
    next_cycle();
    reset = 1'b1;
    #1;
    checks++;
    if (rn_ready !== 1'b1) begin fails++; $display("[TB] FAIL rstrec_ready: got %0b expected 1", rn_ready); end
    read_map(5'd11, v);
    checks++;
    if (v !== 6'd11) begin fails++; $display("[TB] FAIL rstrec_map11: got %0d expected 11", v); end
    read_map(5'd2, v);
    checks++;
    if (v !== 6'd2) begin fails++; $display("[TB] FAIL rstrec_map2: got %0d expected 2", v); end
    @(negedge clock);
    reset = 1'b0;
    next_cycle();
    flush_valid = 1'b1;
    next_cycle();
    next_cycle();
    read_map(5'd11, v);
    checks++;
    if (v !== 6'd11) begin fails++; $display("[TB] FAIL rstrec_arat11: got %0d expected 11", v); end
    read_map(5'd9, v);
    checks++;
    if (v !== 6'd9) begin fails++; $display("[TB] FAIL rstrec_arat9: got %0d expected 9", v); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_basic_rename();
    test_bypass();
    test_x0();
    test_flush_recovery();
    test_commit_in_flush();
    test_back_to_back();
    test_reset_in_recover();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/spec_rename_table.md
# spec_rename_table

Parametrised speculative/architectural register alias table for the rename stage. Per rename lane it maps logical sources to physical registers, returns the old mapping of the destination for later freeing, and records the new mapping, with in-group bypass between lanes. A second, commit-updated architectural table restores the speculative table after a pipeline flush through a one-cycle recovery state.

## Interface
- LREG_NUM, 32: logical registers; LW = $clog2(LREG_NUM)
- PREG_WIDTH, 6: physical register tag width
- RENAME_WIDTH, 2: rename lanes per cycle
- COMMIT_WIDTH, 2: commit lanes per cycle

Lane k occupies bits [k*W +: W] of each packed bus.
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- rn_valid  in  RENAME_WIDTH  lane holds a valid instruction
- rn_rd_wen  in  RENAME_WIDTH  lane writes a destination
- rn_lrs1, rn_lrs2, rn_lrd  in  RENAME_WIDTH*LW  logical sources/destination
- rn_new_prd  in  RENAME_WIDTH*PREG_WIDTH  free-list tag allocated to lrd
- rn_prs1, rn_prs2  out  RENAME_WIDTH*PREG_WIDTH  physical sources
- rn_old_prd  out  RENAME_WIDTH*PREG_WIDTH  previous mapping of lrd
- rn_ready  out  1  table accepts renames this cycle
- cm_valid  in  COMMIT_WIDTH  committing instruction writes a destination
- cm_lrd  in  COMMIT_WIDTH*LW
- cm_prd  in  COMMIT_WIDTH*PREG_WIDTH
- flush_valid  in  1  redirect; discard speculative mappings

## Operation
- Storage: srat[LREG_NUM], arat[LREG_NUM], each PREG_WIDTH; FSM state {RUN, RECOVER}.
- Reset: srat[i] = arat[i] = i (truncated to PREG_WIDTH); state = RUN.
- Reads, combinational from srat: lane k's lrs1/lrs2/lrd mapping is the new_prd of the highest lane j<k with rn_valid[j] & rn_rd_wen[j] & lrd[j]==target & lrd[j]!=0, else srat[target].
- Logical 0: prs1/prs2/old_prd read as 0 whatever srat holds; writes to lrd 0 are dropped, in srat and arat.
- Rename write, when fire[k] = rn_ready & rn_valid[k] & rn_rd_wen[k] & lrd!=0: srat[lrd] <= new_prd. Same lrd on several lanes: highest lane wins.
- Commit write, independent of rn_ready and state: arat[cm_lrd] <= cm_prd per valid lane; highest lane wins. arat_next is arat with this cycle's commits applied.
- rn_ready = (state==RUN) & ~flush_valid.
- FSM:
  - RUN with flush_valid: go to RECOVER; no srat writes.
  - RECOVER: srat <= arat_next for every entry; return to RUN. flush_valid during RECOVER restarts RECOVER, i.e. stays in RECOVER.
  - RUN without flush: stay in RUN.
- Outputs while rn_ready=0 are don't-care. The upstream must hold its group and must not pop the free list.
- Reset mid-RECOVER: both tables return to identity and the FSM returns to RUN.

## Timing
- Read to output: zero cycles, combinational, bypass included.
- A srat write at edge N is visible to reads in cycle N+1.
- Commit at edge N is visible in arat in cycle N+1. It is folded into a RECOVER copy at edge N.
- Flush asserted in cycle N: rn_ready=0 in N and N+1, srat restored at edge N+1, rn_ready=1 in N+2.
- Reset values: rn_ready=1 once reset deasserts. Outputs reflect identity mappings, e.g. rn_prs1 of lrs1=5 is 5.

## Test plan
- Reset, then rename lane0 lrs1=3, lrs2=0, lrd=7, new_prd=40 -> prs1=3, prs2=0, old_prd=7. Next cycle a read of lrs1=7 returns 40.
- Same-cycle bypass: lane0 lrd=4/new 33, lane1 lrs1=4, lrd=4/new 34 -> lane1 prs1=33, old_prd=33. Next cycle srat[4]=34.
- lrd=0 with rd_wen, new_prd=50 -> old_prd=0. srat[0] is unchanged and reads of x0 stay 0.
- Flush recovery:
  - Stimulus: rename lrd=9 to 41, commit lrd=9 prd=20, then flush.
  - rn_ready is low for exactly 2 cycles; a rename offered then is not written.
  - Afterwards srat[9]=20 and the other entries equal arat.
- Commit in the flush cycle: commit lrd=2 prd=60 together with flush_valid -> srat[2]=60 after RECOVER. Two commit lanes with the same lrd -> higher lane's prd kept.
- Back-to-back flushes, and reset asserted during RECOVER:
  - Back-to-back flushes keep rn_ready low until one cycle after the last flush.
  - Reset during RECOVER restores the identity mapping immediately, asynchronously.
